// File: rtl/red_sampler_pkg.sv
// State encoding and default timing for the RED LED ADC sampler.
// The dark-capture states exist only when RED_AMBIENT_SUB_EN is defined.
package red_sampler_pkg;

    localparam int unsigned SETTLE_CYCLES_DEF  = 16;
    localparam int unsigned TIMEOUT_CYCLES_DEF = 64;
    localparam int unsigned PERIOD_CYCLES_DEF  = 1000;
    localparam int unsigned DATA_W             = 8;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SETTLE    = 3'd1,
        CONVERT   = 3'd2,
        WAIT_DONE = 3'd3,
        GAP       = 3'd4
`ifdef RED_AMBIENT_SUB_EN
        ,
        DARK_SETTLE  = 3'd5,
        DARK_CONVERT = 3'd6,
        DARK_WAIT    = 3'd7
`endif
    } state_e;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/adc_conv_handshake.sv
// ADC handshake: registered start pulse, done qualification and wait timeout.
// Shared by the lit and dark conversions of the RED sampler.
module adc_conv_handshake
    import red_sampler_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic CLK_Sample,
    input  logic rst,
    input  logic start_req,
    input  logic wait_en,
    input  logic adc_done,
    output logic adc_start,
    output logic done_c,
    output logic timeout_c
);

    localparam int unsigned TMO_W = cnt_w(TIMEOUT_CYCLES);

    logic [TMO_W-1:0] tmo_cnt_q;

    // Wait counter restarts from zero on every entry to a wait state.
    always_ff @(posedge CLK_Sample or posedge rst) begin
        if (rst) begin
            adc_start <= 1'b0;
            tmo_cnt_q <= '0;
        end else begin
            adc_start <= start_req;
            tmo_cnt_q <= wait_en ? tmo_cnt_q + TMO_W'(1) : '0;
        end
    end

    // A done arriving on the last wait cycle takes priority over the timeout.
    assign done_c    = wait_en & adc_done;
    assign timeout_c = wait_en & ~adc_done & (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/red_adc_sampler.sv
// RED LED sampler: settle, convert, capture once per fixed-length frame.
// Define RED_AMBIENT_SUB_EN to add a dark capture and output max(lit - dark, 0).
module red_adc_sampler
    import red_sampler_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES  = SETTLE_CYCLES_DEF,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    parameter int unsigned PERIOD_CYCLES  = PERIOD_CYCLES_DEF
) (
    input  logic              CLK_Sample,
    input  logic              rst,
    input  logic              Enable,
    input  logic [DATA_W-1:0] ADC_Data,
    input  logic              ADC_Done,
    output logic              ADC_Start,
    output logic              LED_RED,
    output logic [DATA_W-1:0] RED_ADC_Value,
    output logic              Sample_Valid,
    output logic              Timeout_Err
);

    localparam int unsigned SET_W = cnt_w(SETTLE_CYCLES);
    localparam int unsigned FRM_W = cnt_w(PERIOD_CYCLES);

    state_e            state_q;
    state_e            state_d;
    logic [SET_W-1:0]  set_cnt_q;
    logic [FRM_W-1:0]  frm_cnt_q;
    logic              start_req;
    logic              wait_en;
    logic              done_c;
    logic              timeout_c;
    logic              led_d;
    logic              valid_d;
    logic              err_set;
    logic              val_load;
    logic [DATA_W-1:0] val_d;
`ifdef RED_AMBIENT_SUB_EN
    logic [DATA_W-1:0] lit_q;
    logic              lit_load;
`endif

`ifdef RED_AMBIENT_SUB_EN
    assign wait_en = (state_q == WAIT_DONE) || (state_q == DARK_WAIT);
`else
    assign wait_en = (state_q == WAIT_DONE);
`endif

    adc_conv_handshake #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_handshake (
        .CLK_Sample (CLK_Sample),
        .rst        (rst),
        .start_req  (start_req),
        .wait_en    (wait_en),
        .adc_done   (ADC_Done),
        .adc_start  (ADC_Start),
        .done_c     (done_c),
        .timeout_c  (timeout_c)
    );

    // Next state and next output values.
    always_comb begin
        state_d  = state_q;
        val_load = 1'b0;
        val_d    = ADC_Data;
        valid_d  = 1'b0;
        err_set  = 1'b0;
`ifdef RED_AMBIENT_SUB_EN
        lit_load = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (Enable) state_d = SETTLE;
            end
            SETTLE: begin
                if (set_cnt_q == SET_W'(SETTLE_CYCLES - 1)) state_d = CONVERT;
            end
            CONVERT: begin
                state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (done_c) begin
`ifdef RED_AMBIENT_SUB_EN
                    lit_load = 1'b1;
                    state_d  = DARK_SETTLE;
`else
                    val_load = 1'b1;
                    valid_d  = 1'b1;
                    state_d  = GAP;
`endif
                end else if (timeout_c) begin
                    err_set = 1'b1;
                    state_d = GAP;
                end
            end
            GAP: begin
                if (frm_cnt_q == FRM_W'(PERIOD_CYCLES - 1)) state_d = Enable ? SETTLE : IDLE;
            end
`ifdef RED_AMBIENT_SUB_EN
            DARK_SETTLE: begin
                if (set_cnt_q == SET_W'(SETTLE_CYCLES - 1)) state_d = DARK_CONVERT;
            end
            DARK_CONVERT: begin
                state_d = DARK_WAIT;
            end
            DARK_WAIT: begin
                if (done_c) begin
                    val_load = 1'b1;
                    valid_d  = 1'b1;
                    val_d    = (lit_q > ADC_Data) ? DATA_W'(lit_q - ADC_Data) : '0;
                    state_d  = GAP;
                end else if (timeout_c) begin
                    err_set = 1'b1;
                    state_d = GAP;
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase

        led_d = (state_d == SETTLE) || (state_d == CONVERT) || (state_d == WAIT_DONE);
`ifdef RED_AMBIENT_SUB_EN
        start_req = (state_d == CONVERT) || (state_d == DARK_CONVERT);
`else
        start_req = (state_d == CONVERT);
`endif
    end

    // State, counters and registered outputs.
    always_ff @(posedge CLK_Sample or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            set_cnt_q     <= '0;
            frm_cnt_q     <= '0;
            LED_RED       <= 1'b0;
            Sample_Valid  <= 1'b0;
            Timeout_Err   <= 1'b0;
            RED_ADC_Value <= '0;
`ifdef RED_AMBIENT_SUB_EN
            lit_q         <= '0;
`endif
        end else begin
            state_q <= state_d;

            if (state_d == state_q &&
`ifdef RED_AMBIENT_SUB_EN
                (state_q == SETTLE || state_q == DARK_SETTLE))
`else
                (state_q == SETTLE))
`endif
                set_cnt_q <= set_cnt_q + SET_W'(1);
            else
                set_cnt_q <= '0;

            // Frame counter is zero in the first SETTLE cycle of every frame.
            if (state_d == SETTLE && state_q != SETTLE)
                frm_cnt_q <= '0;
            else if (state_q != IDLE)
                frm_cnt_q <= frm_cnt_q + FRM_W'(1);
            else
                frm_cnt_q <= '0;

            LED_RED      <= led_d;
            Sample_Valid <= valid_d;
            Timeout_Err  <= Timeout_Err | err_set;
            if (val_load) RED_ADC_Value <= val_d;
`ifdef RED_AMBIENT_SUB_EN
            if (lit_load) lit_q <= ADC_Data;
`endif
        end
    end

endmodule

// File: tb/tb_red_adc_sampler.sv
// Randomized frame-level bench for red_adc_sampler (default build).
module tb_red_adc_sampler;

    localparam int SETTLE = 16;
    localparam int TMO    = 64;
    localparam int PERIOD = 1000;

    logic       CLK_Sample = 1'b0;
    logic       rst;
    logic       Enable;
    logic [7:0] ADC_Data;
    logic       ADC_Done;
    logic       ADC_Start;
    logic       LED_RED;
    logic [7:0] RED_ADC_Value;
    logic       Sample_Valid;
    logic       Timeout_Err;

    int compared   = 0;
    int mismatched = 0;

    int cyc;
    int done_cyc, done_off, spur_cyc, drop_cyc;
    logic [7:0] resp_data;
    int led_first, led_last, st_cnt, st_cyc, vl_cnt, vl_cyc;
    logic [7:0] exp_val;
    logic       exp_err;

    red_adc_sampler dut (
        .CLK_Sample    (CLK_Sample),
        .rst           (rst),
        .Enable        (Enable),
        .ADC_Data      (ADC_Data),
        .ADC_Done      (ADC_Done),
        .ADC_Start     (ADC_Start),
        .LED_RED       (LED_RED),
        .RED_ADC_Value (RED_ADC_Value),
        .Sample_Valid  (Sample_Valid),
        .Timeout_Err   (Timeout_Err)
    );

    always #5 CLK_Sample = ~CLK_Sample;

    // One clock cycle: drive after the rising edge, observe on the falling edge.
    task automatic tick();
        @(posedge CLK_Sample);
        cyc++;
        #1;
        if (cyc == drop_cyc) Enable = 1'b0;
        ADC_Done = (cyc == done_cyc) || (cyc == spur_cyc);
        if (cyc == done_cyc)      ADC_Data = resp_data;
        else if (cyc == spur_cyc) ADC_Data = ~exp_val;
        else                      ADC_Data = 8'($urandom);
        @(negedge CLK_Sample);
        if (LED_RED) begin
            if (led_first < 0) led_first = cyc;
            led_last = cyc;
        end
        if (ADC_Start) begin
            st_cnt++;
            st_cyc = cyc;
            if (done_off > 0) done_cyc = cyc + done_off;
        end
        if (Sample_Valid) begin
            vl_cnt++;
            vl_cyc = cyc;
        end
    endtask

    task automatic clear_obs();
        led_first = -1; led_last = -1; st_cnt = 0; st_cyc = -1;
        vl_cnt = 0; vl_cyc = -1; done_cyc = -1; spur_cyc = -1;
    endtask

    task automatic test_reset();
        rst = 1'b1; Enable = 1'b0; ADC_Done = 1'b0; ADC_Data = 8'h00;
        cyc = 0; done_off = 0; drop_cyc = -1; exp_val = 8'h00; exp_err = 1'b0;
        clear_obs();
        repeat (3) @(negedge CLK_Sample);
        compared++;
        if ({ADC_Start, LED_RED, Sample_Valid, Timeout_Err, RED_ADC_Value} !== 12'h000) begin
            mismatched++;
            $display("FAIL reset_outputs: got %b/%b/%b/%b/%h expected all zero",
                     ADC_Start, LED_RED, Sample_Valid, Timeout_Err, RED_ADC_Value);
        end
        rst = 1'b0;
        @(negedge CLK_Sample);
        cyc = 0;
        Enable = 1'b1;
    endtask

    // Runs one full frame starting at cycle f and checks it against the frame rules.
    task automatic test_frame(input string name, input int f, input int off,
                              input logic [7:0] data, input int spur);
        logic ok;
        int   exp_last;
        clear_obs();
        done_off  = off;
        resp_data = data;
        spur_cyc  = (spur > 0) ? f + spur : -1;
        while (cyc < f + PERIOD - 1) tick();
        ok       = (off >= 1) && (off <= TMO);
        exp_last = f + SETTLE + (ok ? off : TMO);
        if (ok) exp_val = data;
        else    exp_err = 1'b1;

        compared++;
        if (led_first !== f) begin
            mismatched++;
            $display("FAIL %s led_first: got %0d expected %0d", name, led_first, f);
        end
        compared++;
        if (led_last !== exp_last) begin
            mismatched++;
            $display("FAIL %s led_last: got %0d expected %0d", name, led_last, exp_last);
        end
        compared++;
        if (st_cnt !== 1 || st_cyc !== f + SETTLE) begin
            mismatched++;
            $display("FAIL %s adc_start: got %0d pulses at %0d expected 1 at %0d",
                     name, st_cnt, st_cyc, f + SETTLE);
        end
        compared++;
        if (vl_cnt !== (ok ? 1 : 0)) begin
            mismatched++;
            $display("FAIL %s valid_count: got %0d expected %0d", name, vl_cnt, ok ? 1 : 0);
        end
        if (ok) begin
            compared++;
            if (vl_cyc !== exp_last + 1) begin
                mismatched++;
                $display("FAIL %s valid_cycle: got %0d expected %0d", name, vl_cyc, exp_last + 1);
            end
        end
        compared++;
        if (RED_ADC_Value !== exp_val) begin
            mismatched++;
            $display("FAIL %s value: got %h expected %h", name, RED_ADC_Value, exp_val);
        end
        compared++;
        if (Timeout_Err !== exp_err) begin
            mismatched++;
            $display("FAIL %s timeout_err: got %b expected %b", name, Timeout_Err, exp_err);
        end
    endtask

    task automatic test_basic();
        test_frame("basic", 1, 4, 8'h5A, 0);
    endtask

    task automatic test_coincident();
        test_frame("coincident", cyc + 1, TMO, 8'($urandom), 0);
    endtask

    task automatic test_random(input int n);
        for (int i = 0; i < n; i++) begin
            int sp;
            sp = ($urandom_range(0, 1) == 1) ? $urandom_range(2, SETTLE - 2) : $urandom_range(90, 990);
            test_frame("random", cyc + 1, $urandom_range(1, TMO), 8'($urandom), sp);
        end
    endtask

    task automatic test_timeout();
        test_frame("timeout", cyc + 1, 0, 8'h00, 200);
    endtask

    task automatic test_enable_drop();
        int f;
        f = cyc + 1;
        drop_cyc = f + SETTLE + 3;
        test_frame("enable_drop", f, $urandom_range(5, TMO), 8'($urandom), 0);
        drop_cyc = -1;
        clear_obs();
        repeat (30) tick();
        compared++;
        if (led_first !== -1 || st_cnt !== 0) begin
            mismatched++;
            $display("FAIL enable_drop_idle: got led_first %0d starts %0d expected -1 and 0",
                     led_first, st_cnt);
        end
    endtask

    task automatic test_reset_mid();
        Enable = 1'b1;
        repeat (6) tick();
        compared++;
        if (LED_RED !== 1'b1) begin
            mismatched++;
            $display("FAIL reset_mid_settle_led: got %b expected 1", LED_RED);
        end
        #2 rst = 1'b1;
        #1;
        compared++;
        if ({ADC_Start, LED_RED, Sample_Valid, Timeout_Err, RED_ADC_Value} !== 12'h000) begin
            mismatched++;
            $display("FAIL reset_mid_outputs: got %b/%b/%b/%b/%h expected all zero",
                     ADC_Start, LED_RED, Sample_Valid, Timeout_Err, RED_ADC_Value);
        end
        Enable = 1'b0;
        clear_obs();
        repeat (20) tick();
        @(negedge CLK_Sample);
        rst = 1'b0;
        repeat (20) tick();
        compared++;
        if (vl_cnt !== 0 || led_first !== -1 || st_cnt !== 0) begin
            mismatched++;
            $display("FAIL reset_mid_quiet: got valid %0d led_first %0d starts %0d expected 0 -1 0",
                     vl_cnt, led_first, st_cnt);
        end
        compared++;
        if (Timeout_Err !== 1'b0 || RED_ADC_Value !== 8'h00) begin
            mismatched++;
            $display("FAIL reset_mid_state: got err %b value %h expected 0 00",
                     Timeout_Err, RED_ADC_Value);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_coincident();
        test_random(4);
        test_timeout();
        test_enable_drop();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
